ow_temp_seq: RTL
================

OW_TEMP_SEQ -- requirements
Module: ow_temp_seq

Interface
REQ-001 SHALL have parameter CONV_TMO_CYC, default 7_500_000, conversion-poll timeout in clocks (750 ms at 10 MHz).
REQ-002 SHALL have parameter POLL_GAP_CYC, default 1000, idle clocks between conversion-done polls.
REQ-003 SHALL have port clk_10, input, 1, the single clock.
REQ-004 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request for one temperature measurement.
REQ-006 SHALL have port busy, output, 1, high from accepted start until done/error.
REQ-007 SHALL have port temp, output, 16, last good scratchpad bytes {byte1,byte0}.
REQ-008 SHALL have port temp_vld, output, 1, one-cycle pulse when temp updates.
REQ-009 SHALL have port err, output, 2, status pulse: 01 no presence, 10 timeout, 11 CRC fail.
REQ-010 SHALL have ports mst_vld (out,1), mst_we (out,1), mst_bits (out,5), mst_wdat (out,8), mst_rdy (in,1), mst_rdat (in,8), the onewire_master transfer handshake.
REQ-011 SHALL have ports mst_rst_req (out,1), mst_rst_done (in,1), mst_presence (in,1), the bus reset/presence handshake.

Function
REQ-012 Transfer handshake: mst_vld, mst_we, mst_bits, mst_wdat held stable from assertion until the cycle mst_rdy=1; mst_vld drops the following cycle; mst_rdat sampled in the mst_rdy cycle when mst_we=0.
REQ-013 Reset handshake: mst_rst_req held until mst_rst_done=1; mst_presence sampled in that cycle.
REQ-014 FSM states: IDLE, RST1, SKIP1, CONVT, POLL, GAP, RST2, SKIP2, RDCMD, RDBYTE, DONE, ERR.
REQ-015 IDLE->RST1 on start=1; start while busy=1 is ignored.
REQ-016 RST1/RST2: presence=0 -> ERR with err=01; else -> SKIP1/SKIP2.
REQ-017 SKIP1/SKIP2: write 0xCC, 8 bits -> CONVT/RDCMD.
REQ-018 CONVT: write 0x44, 8 bits -> POLL; clears and starts 32-bit timeout counter.
REQ-019 POLL: read 1 bit; mst_rdat[0]=1 -> RST2; =0 -> GAP.
REQ-020 GAP: wait POLL_GAP_CYC clocks -> POLL.
REQ-021 Timeout counter increments every cycle in POLL/GAP; reaching CONV_TMO_CYC -> ERR with err=10, after any in-flight transfer completes (never abandon mst_vld before mst_rdy).
REQ-022 RDCMD: write 0xBE, 8 bits -> RDBYTE, byte index 0.
REQ-023 RDBYTE: read 8 bits per transfer, bytes stored by index; index wraps never -- last index exits to DONE.
REQ-024 DONE: temp <= {byte1,byte0}, temp_vld pulse 1 cycle -> IDLE.
REQ-025 ERR: err pulse 1 cycle, temp unchanged -> IDLE.
REQ-026 busy=1 in all states except IDLE; busy falls the cycle after DONE/ERR.
REQ-027 At most one of mst_vld, mst_rst_req asserted in any cycle.
REQ-028 Start-to-first mst_rst_req latency: 1 clock.

Reset
REQ-029 arst_n=0 asynchronously forces IDLE; busy, temp_vld, mst_vld, mst_we, mst_rst_req = 0; mst_bits=0; mst_wdat=0; temp=16'h0000; err=00; counters=0.
REQ-030 Reset mid-transfer abandons the transfer; no output pulses result; first start after release begins at RST1.
REQ-031 Reset release is synchronised internally (two-flop) before FSM leaves IDLE.

Configuration
REQ-032 Macro OW_SEQ_CRC_EN defined: RDBYTE reads 9 bytes, runs Dallas CRC-8 (x^8+x^5+x^4+1, LSB first, init 0) over all 9; residue!=0 -> ERR err=11, else DONE.
REQ-033 Macro OW_SEQ_CRC_EN undefined: RDBYTE reads 2 bytes -> DONE; err=11 never generated; no CRC logic present.

Verification
REQ-034 Slave returns presence, done bit 1 on first poll, scratchpad 0x50,0x05,...,CRC -> temp=16'h0550, one temp_vld pulse, err=00.
REQ-035 No presence on RST1 -> err=01 pulse, no write transfers issued, temp retains previous value.
REQ-036 Done bit held 0, CONV_TMO_CYC=5000 -> err=10 pulse after ~5000 clocks, no RST2 issued.
REQ-037 With OW_SEQ_CRC_EN, corrupt scratchpad byte 4 -> err=11, temp unchanged; without macro, same stimulus -> temp updated after 2 bytes.
REQ-038 Start asserted again during POLL -> ignored, exactly one temp_vld pulse; write sequence observed = CC,44,CC,BE.
REQ-039 arst_n asserted while mst_vld=1 in RDBYTE -> all outputs at reset values immediately; next start completes normally.

Source files
------------

// File: rtl/ow_temp_seq.sv
// ow_temp_seq: sequences one 1-Wire temperature measurement through an
// external onewire_master: reset/presence, skip ROM, convert T, poll for
// conversion done, reset/presence, skip ROM, read scratchpad.
// Optional feature: define OW_SEQ_CRC_EN to read all 9 scratchpad bytes and
// reject the result when the Dallas CRC-8 residue is non-zero.
module ow_temp_seq #(
    parameter int unsigned CONV_TMO_CYC = 7_500_000,
    parameter int unsigned POLL_GAP_CYC = 1000
) (
    input  logic        clk_10,
    input  logic        arst_n,
    input  logic        start,
    output logic        busy,
    output logic [15:0] temp,
    output logic        temp_vld,
    output logic [1:0]  err,
    output logic        mst_vld,
    output logic        mst_we,
    output logic [4:0]  mst_bits,
    output logic [7:0]  mst_wdat,
    input  logic        mst_rdy,
    input  logic [7:0]  mst_rdat,
    output logic        mst_rst_req,
    input  logic        mst_rst_done,
    input  logic        mst_presence
);

`ifdef OW_SEQ_CRC_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd1;
`endif

    typedef enum logic [3:0] {
        IDLE, RST1, SKIP1, CONVT, POLL, GAP,
        RST2, SKIP2, RDCMD, RDBYTE, DONE, ERR
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  rst_sync;
    logic        sync_ok;
    logic        hold;
    logic [31:0] tmo_cnt;
    logic [31:0] gap_cnt;
    logic        tmo_hit;
    logic        gap_end;
    logic [3:0]  idx;
    logic [7:0]  byte0;
    logic [1:0]  err_code;
    logic [1:0]  err_set;
    logic        load_temp;
    logic [15:0] temp_new;

`ifdef OW_SEQ_CRC_EN
    logic [7:0]  byte1;
    logic [7:0]  crc;
    logic [7:0]  crc_nx;

    // Dallas CRC-8 (x^8+x^5+x^4+1), bits consumed LSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    assign crc_nx   = crc8_step(crc, mst_rdat);
    assign temp_new = {byte1, byte0};
`else
    assign temp_new = {mst_rdat, byte0};
`endif

    assign sync_ok = rst_sync[1];
    assign tmo_hit = (tmo_cnt >= CONV_TMO_CYC);
    assign gap_end = ((gap_cnt + 32'd1) >= POLL_GAP_CYC);

    // Two-flop synchroniser so the FSM only starts once reset release is clean
    always_ff @(posedge clk_10 or negedge arst_n) begin
        if (!arst_n) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    // State register
    always_ff @(posedge clk_10 or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Bus handshake outputs decoded from state, then next-state selection
    always_comb begin
        state_nx    = state;
        err_set     = 2'b00;
        load_temp   = 1'b0;
        mst_vld     = 1'b0;
        mst_we      = 1'b0;
        mst_bits    = 5'd0;
        mst_wdat    = 8'h00;
        mst_rst_req = 1'b0;
        busy        = (state != IDLE);
        temp_vld    = (state == DONE);
        err         = (state == ERR) ? err_code : 2'b00;

        case (state)
            RST1, RST2:     mst_rst_req = !hold;
            SKIP1, SKIP2: begin
                mst_vld = !hold; mst_we = !hold;
                mst_bits = hold ? 5'd0 : 5'd8; mst_wdat = hold ? 8'h00 : 8'hCC;
            end
            CONVT: begin
                mst_vld = !hold; mst_we = !hold;
                mst_bits = hold ? 5'd0 : 5'd8; mst_wdat = hold ? 8'h00 : 8'h44;
            end
            RDCMD: begin
                mst_vld = !hold; mst_we = !hold;
                mst_bits = hold ? 5'd0 : 5'd8; mst_wdat = hold ? 8'h00 : 8'hBE;
            end
            POLL: begin
                mst_vld = !hold; mst_bits = hold ? 5'd0 : 5'd1;
            end
            RDBYTE: begin
                mst_vld = !hold; mst_bits = hold ? 5'd0 : 5'd8;
            end
            default: ;
        endcase

        case (state)
            IDLE:   if (start && sync_ok) state_nx = RST1;
            RST1, RST2: begin
                if (mst_rst_req && mst_rst_done) begin
                    if (!mst_presence) begin
                        state_nx = ERR;
                        err_set  = 2'b01;
                    end else begin
                        state_nx = (state == RST1) ? SKIP1 : SKIP2;
                    end
                end
            end
            SKIP1:  if (mst_vld && mst_rdy) state_nx = CONVT;
            CONVT:  if (mst_vld && mst_rdy) state_nx = POLL;
            POLL: begin
                if (mst_vld && mst_rdy) begin
                    if (tmo_hit) begin
                        state_nx = ERR;
                        err_set  = 2'b10;
                    end else begin
                        state_nx = mst_rdat[0] ? RST2 : GAP;
                    end
                end else if (hold && tmo_hit) begin
                    state_nx = ERR;
                    err_set  = 2'b10;
                end
            end
            GAP: begin
                if (tmo_hit) begin
                    state_nx = ERR;
                    err_set  = 2'b10;
                end else if (gap_end) begin
                    state_nx = POLL;
                end
            end
            SKIP2:  if (mst_vld && mst_rdy) state_nx = RDCMD;
            RDCMD:  if (mst_vld && mst_rdy) state_nx = RDBYTE;
            RDBYTE: begin
                if (mst_vld && mst_rdy && idx == LAST_IDX) begin
`ifdef OW_SEQ_CRC_EN
                    if (crc_nx != 8'h00) begin
                        state_nx = ERR;
                        err_set  = 2'b11;
                    end else begin
                        state_nx  = DONE;
                        load_temp = 1'b1;
                    end
`else
                    state_nx  = DONE;
                    load_temp = 1'b1;
`endif
                end
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake spacing, timeout/gap counters, scratchpad capture and result registers
    always_ff @(posedge clk_10 or negedge arst_n) begin
        if (!arst_n) begin
            hold     <= 1'b0;
            tmo_cnt  <= 32'd0;
            gap_cnt  <= 32'd0;
            idx      <= 4'd0;
            byte0    <= 8'h00;
            err_code <= 2'b00;
            temp     <= 16'h0000;
`ifdef OW_SEQ_CRC_EN
            byte1    <= 8'h00;
            crc      <= 8'h00;
`endif
        end else begin
            hold <= (mst_vld && mst_rdy) || (mst_rst_req && mst_rst_done);

            if (state == CONVT)
                tmo_cnt <= 32'd0;
            else if ((state == POLL || state == GAP) && !tmo_hit)
                tmo_cnt <= tmo_cnt + 32'd1;

            if (state == GAP) gap_cnt <= gap_cnt + 32'd1;
            else              gap_cnt <= 32'd0;

            if (state == RDCMD) begin
                idx <= 4'd0;
`ifdef OW_SEQ_CRC_EN
                crc <= 8'h00;
`endif
            end else if (state == RDBYTE && mst_vld && mst_rdy) begin
                idx <= idx + 4'd1;
                if (idx == 4'd0) byte0 <= mst_rdat;
`ifdef OW_SEQ_CRC_EN
                if (idx == 4'd1) byte1 <= mst_rdat;
                crc <= crc_nx;
`endif
            end

            if (err_set != 2'b00) err_code <= err_set;
            if (load_temp)        temp     <= temp_new;
        end
    end

endmodule
